// File: rtl/chip8_sprite_draw_pkg.sv
// Shared types and constants for the CHIP-8 DXYN sprite draw sequencer.
package chip8_sprite_draw_pkg;

  localparam int FB_WIDTH  = 64;
  localparam int FB_HEIGHT = 32;

  typedef logic [2:0] draw_state_t;

  localparam draw_state_t S_IDLE   = 3'd0;
  localparam draw_state_t S_FETCH  = 3'd1;
  localparam draw_state_t S_LATCH  = 3'd2;
  localparam draw_state_t S_PIX_RD = 3'd3;
  localparam draw_state_t S_PIX_WR = 3'd4;
  localparam draw_state_t S_DONE   = 3'd5;

  // Draw parameters frozen at the accepted start.
  typedef struct packed {
    logic [3:0]  n;
    logic [11:0] base;
  } draw_req_t;

  function automatic logic [11:0] row_addr(input logic [11:0] base, input logic [3:0] row);
    return base + {8'h00, row};
  endfunction

endpackage

// File: rtl/chip8_sprite_draw_if.sv
// Execute-stage handshake plus memory and framebuffer ports of the sprite sequencer.
interface chip8_sprite_draw_if #(
  parameter int FB_X_BITS = 6,
  parameter int FB_Y_BITS = 5
);
  logic                 start;
  logic [7:0]           vx;
  logic [7:0]           vy;
  logic [3:0]           n;
  logic [15:0]          reg_i;
  logic                 busy;
  logic                 done;
  logic                 collision;
  logic [11:0]          mem_addr;
  logic [7:0]           mem_readdata;
  logic [FB_X_BITS-1:0] fb_rd_x;
  logic [FB_Y_BITS-1:0] fb_rd_y;
  logic                 fb_rd_bit;
  logic [FB_X_BITS-1:0] fb_wr_x;
  logic [FB_Y_BITS-1:0] fb_wr_y;
  logic                 fb_wr_bit;
  logic                 fb_we;

  // master: execute stage / top-level muxes; slave: the draw sequencer
  modport master (
    output start, vx, vy, n, reg_i, mem_readdata, fb_rd_bit,
    input  busy, done, collision, mem_addr, fb_rd_x, fb_rd_y,
           fb_wr_x, fb_wr_y, fb_wr_bit, fb_we
  );

  modport slave (
    input  start, vx, vy, n, reg_i, mem_readdata, fb_rd_bit,
    output busy, done, collision, mem_addr, fb_rd_x, fb_rd_y,
           fb_wr_x, fb_wr_y, fb_wr_bit, fb_we
  );
endinterface

// File: rtl/chip8_sprite_draw.sv
// DXYN sequencer: fetches N sprite rows and XORs set bits into the framebuffer,
// one read/write pixel pair per bit, flagging collision when a lit pixel clears.
module chip8_sprite_draw
  import chip8_sprite_draw_pkg::*;
#(
  parameter int FB_X_BITS = 6,
  parameter int FB_Y_BITS = 5
) (
  input  logic               clk,
  input  logic               reset,
  chip8_sprite_draw_if.slave bus
);

  draw_state_t          state;
  draw_req_t            req;
  logic [FB_X_BITS-1:0] x0;
  logic [FB_Y_BITS-1:0] y0;
  logic [3:0]           row;
  logic [2:0]           col;
  logic [7:0]           sprite;
  logic                 coll_q;

  logic                 last_col;
  logic                 last_row;
  logic [FB_X_BITS-1:0] px_x;
  logic [FB_Y_BITS-1:0] px_y;
  logic                 px_we;
  logic                 unused_bits;

  assign last_col = (col == 3'd7);
  assign last_row = (row == req.n - 4'd1);
  assign unused_bits = ^{bus.reg_i[15:12], bus.vx, bus.vy};

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      req    <= '0;
      x0     <= '0;
      y0     <= '0;
      row    <= '0;
      col    <= '0;
      sprite <= '0;
      coll_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (bus.start) begin
          req    <= '{n: bus.n, base: bus.reg_i[11:0]};
          x0     <= bus.vx[FB_X_BITS-1:0];
          y0     <= bus.vy[FB_Y_BITS-1:0];
          row    <= '0;
          col    <= '0;
          coll_q <= 1'b0;
          state  <= (bus.n == 4'd0) ? S_DONE : S_FETCH;
        end
        S_FETCH: state <= S_LATCH;
        S_LATCH: begin
          sprite <= bus.mem_readdata;
          col    <= '0;
          state  <= S_PIX_RD;
        end
        S_PIX_RD: state <= S_PIX_WR;
        S_PIX_WR: begin
          // sprite[7] always holds bit [7-col]; shifted once per pixel
          if (sprite[7] && bus.fb_rd_bit) coll_q <= 1'b1;
          sprite <= {sprite[6:0], 1'b0};
          if (!last_col) begin
            col   <= col + 3'd1;
            state <= S_PIX_RD;
          end else if (!last_row) begin
            row   <= row + 4'd1;
            state <= S_FETCH;
          end else begin
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Coordinates wrap by truncation to the address width.
  assign px_x  = x0 + FB_X_BITS'(col);
  assign px_y  = y0 + FB_Y_BITS'(row);
  assign px_we = (state == S_PIX_WR) && sprite[7];

  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = (state == S_DONE);
  assign bus.collision = coll_q;
  assign bus.mem_addr  = row_addr(req.base, row);
  assign bus.fb_rd_x   = px_x;
  assign bus.fb_rd_y   = px_y;
  assign bus.fb_wr_x   = px_x;
  assign bus.fb_wr_y   = px_y;
  assign bus.fb_we     = px_we;
  assign bus.fb_wr_bit = px_we & ~bus.fb_rd_bit;

endmodule

// File: tb/tb_chip8_sprite_draw.sv
// Randomized bench for chip8_sprite_draw against a whole-sprite XOR reference model.
module tb_chip8_sprite_draw;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  chip8_sprite_draw_if #(.FB_X_BITS(6), .FB_Y_BITS(5)) dif();

  chip8_sprite_draw #(.FB_X_BITS(6), .FB_Y_BITS(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif)
  );

  logic [7:0] mem [4096];
  bit fb      [64][32];
  bit fb_init [64][32];
  bit exp_fb  [64][32];
  logic fb_load = 1'b0;
  logic [7:0] mem_q;
  logic fb_q;

  // Memory and framebuffer models with one-cycle read latency
  always @(posedge clk) begin
    mem_q <= mem[dif.mem_addr];
    fb_q  <= fb[dif.fb_rd_x][dif.fb_rd_y];
    if (fb_load) begin
      for (int x = 0; x < 64; x++)
        for (int y = 0; y < 32; y++)
          fb[x][y] <= fb_init[x][y];
    end else if (dif.fb_we) begin
      fb[dif.fb_wr_x][dif.fb_wr_y] <= dif.fb_wr_bit;
    end
  end
  assign dif.mem_readdata = mem_q;
  assign dif.fb_rd_bit    = fb_q;

  int checks = 0;
  int errors = 0;
  int done_cyc, done_cnt, we_cnt;
  bit we_b2b;
  logic [11:0] addr_q[$];
  logic exp_coll;
  int exp_we;
  logic [11:0] exp_addr[$];

  task automatic load_fb(input int mode);
    for (int x = 0; x < 64; x++)
      for (int y = 0; y < 32; y++)
        fb_init[x][y] = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : bit'($urandom_range(0, 1));
    @(negedge clk) fb_load = 1'b1;
    @(negedge clk) fb_load = 1'b0;
  endtask

  // Whole-draw outcome from the DXYN rules: XOR each set bit, wrap coordinates.
  task automatic model(input logic [7:0] vx, input logic [7:0] vy, input logic [3:0] n,
                       input logic [15:0] ri);
    int a, x, y;
    logic [7:0] b;
    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 32; j++)
        exp_fb[i][j] = fb[i][j];
    exp_coll = 1'b0;
    exp_we = 0;
    exp_addr.delete();
    for (int r = 0; r < int'(n); r++) begin
      a = (int'(ri) + r) % 4096;
      exp_addr.push_back(12'(a));
      b = mem[a];
      for (int c = 0; c < 8; c++) begin
        if (b[7-c]) begin
          x = (int'(vx) + c) % 64;
          y = (int'(vy) + r) % 32;
          if (exp_fb[x][y]) exp_coll = 1'b1;
          exp_fb[x][y] = !exp_fb[x][y];
          exp_we++;
        end
      end
    end
  endtask

  task automatic run_draw(input string tag, input logic [7:0] vx, input logic [7:0] vy,
                          input logic [3:0] n, input logic [15:0] ri, input int poke);
    int c, limit, mm, exp_done;
    logic prev_we;
    model(vx, vy, n, ri);
    exp_done = (n == 0) ? 1 : 18 * int'(n) + 1;
    addr_q.delete();
    done_cyc = -1; done_cnt = 0; we_cnt = 0; we_b2b = 1'b0; prev_we = 1'b0;
    @(negedge clk);
    dif.vx = vx; dif.vy = vy; dif.n = n; dif.reg_i = ri; dif.start = 1'b1;
    @(posedge clk);
    c = 0;
    limit = 18 * 16 + 40;
    while (c < limit) begin
      @(negedge clk);
      c++;
      dif.start = (c == poke);
      if (c == 1) begin
        dif.vx = 8'($urandom); dif.vy = 8'($urandom);
        dif.n = 4'($urandom); dif.reg_i = 16'($urandom);
      end
      if (dif.fb_we) begin
        we_cnt++;
        if (prev_we) we_b2b = 1'b1;
      end
      prev_we = dif.fb_we;
      if (c <= 18 * int'(n) && (c - 1) % 18 == 0) addr_q.push_back(dif.mem_addr);
      if (dif.done) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = c; limit = c + 20; end
      end
    end
    dif.start = 1'b0;
    checks++;
    if (done_cyc !== exp_done) begin errors++;
      $display("FAIL %s done_cycle got %0d want %0d", tag, done_cyc, exp_done); end
    checks++;
    if (done_cnt !== 1) begin errors++;
      $display("FAIL %s done_pulses got %0d want 1", tag, done_cnt); end
    checks++;
    if (dif.collision !== exp_coll) begin errors++;
      $display("FAIL %s collision got %b want %b", tag, dif.collision, exp_coll); end
    checks++;
    if (we_cnt !== exp_we) begin errors++;
      $display("FAIL %s write_count got %0d want %0d", tag, we_cnt, exp_we); end
    checks++;
    if (we_b2b !== 1'b0) begin errors++;
      $display("FAIL %s fb_we_back_to_back got %b want 0", tag, we_b2b); end
    checks++;
    if (addr_q != exp_addr) begin errors++;
      $display("FAIL %s mem_addr_seq got %p want %p", tag, addr_q, exp_addr); end
    mm = 0;
    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 32; j++)
        if (fb[i][j] !== exp_fb[i][j]) mm++;
    checks++;
    if (mm !== 0) begin errors++;
      $display("FAIL %s fb_pixels got %0d wrong want 0", tag, mm); end
    checks++;
    if (dif.busy !== 1'b0) begin errors++;
      $display("FAIL %s busy_after got %b want 0", tag, dif.busy); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    dif.start = 1'b0; dif.vx = '0; dif.vy = '0; dif.n = '0; dif.reg_i = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({dif.busy, dif.done, dif.collision, dif.fb_we, dif.fb_wr_bit} !== 5'b0) begin errors++;
      $display("FAIL reset_ctrl got %b want 00000",
               {dif.busy, dif.done, dif.collision, dif.fb_we, dif.fb_wr_bit}); end
    checks++;
    if ({dif.mem_addr, dif.fb_rd_x, dif.fb_rd_y, dif.fb_wr_x, dif.fb_wr_y} !== 34'b0) begin errors++;
      $display("FAIL reset_addr got %h want 0",
               {dif.mem_addr, dif.fb_rd_x, dif.fb_rd_y, dif.fb_wr_x, dif.fb_wr_y}); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    load_fb(0);
    mem[12'h050] = 8'hF0;
    run_draw("basic", 8'd0, 8'd0, 4'd1, 16'h0050, -1);
    checks++;
    if ({fb[0][0], fb[1][0], fb[2][0], fb[3][0], fb[4][0]} !== 5'b11110) begin errors++;
      $display("FAIL basic_pixels got %b want 11110", {fb[0][0], fb[1][0], fb[2][0], fb[3][0], fb[4][0]}); end
    checks++;
    if (dif.collision !== 1'b0 || done_cyc !== 19) begin errors++;
      $display("FAIL basic_fixed got coll=%b cyc=%0d want coll=0 cyc=19", dif.collision, done_cyc); end
  endtask

  task automatic test_xor();
    run_draw("xor", 8'd0, 8'd0, 4'd1, 16'h0050, -1);
    checks++;
    if ({fb[0][0], fb[1][0], fb[2][0], fb[3][0]} !== 4'b0000 || dif.collision !== 1'b1) begin errors++;
      $display("FAIL xor_fixed got pix=%b coll=%b want pix=0000 coll=1",
               {fb[0][0], fb[1][0], fb[2][0], fb[3][0]}, dif.collision); end
  endtask

  task automatic test_zero();
    run_draw("zero", 8'($urandom), 8'($urandom), 4'd0, 16'($urandom), -1);
    checks++;
    if (done_cyc !== 1 || we_cnt !== 0 || dif.collision !== 1'b0) begin errors++;
      $display("FAIL zero_fixed got cyc=%0d we=%0d coll=%b want cyc=1 we=0 coll=0",
               done_cyc, we_cnt, dif.collision); end
  endtask

  task automatic test_wrap();
    load_fb(0);
    mem[12'h200] = 8'hC3;
    mem[12'h201] = 8'h81;
    run_draw("wrap", 8'h7E, 8'd31, 4'd2, 16'h0200, -1);
    checks++;
    if ({fb[62][31], fb[63][31], fb[4][31], fb[5][31], fb[62][0], fb[5][0], fb[63][0]} !== 7'b1111110
        || done_cyc !== 37) begin errors++;
      $display("FAIL wrap_fixed got pix=%b cyc=%0d want pix=1111110 cyc=37",
               {fb[62][31], fb[63][31], fb[4][31], fb[5][31], fb[62][0], fb[5][0], fb[63][0]}, done_cyc); end
  endtask

  task automatic test_addr_wrap();
    load_fb(2);
    run_draw("addr_wrap", 8'($urandom), 8'($urandom), 4'd2, 16'hAFFF, -1);
    checks++;
    if (addr_q.size() != 2 || addr_q[0] !== 12'hFFF || addr_q[1] !== 12'h000) begin errors++;
      $display("FAIL addr_wrap_fixed got %p want FFF,000", addr_q); end
  endtask

  task automatic test_start_during_busy();
    load_fb(2);
    run_draw("busy_start", 8'($urandom), 8'($urandom), 4'd3, 16'($urandom), 5);
  endtask

  task automatic test_reset_mid();
    int fails;
    fails = 0;
    load_fb(1);
    mem[12'h100] = 8'hFF;
    @(negedge clk);
    dif.vx = 8'd10; dif.vy = 8'd3; dif.n = 4'd3; dif.reg_i = 16'h0100; dif.start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      dif.start = 1'b0;
      if (c == 9) begin
        checks++;
        if (dif.collision !== 1'b1) begin errors++;
          $display("FAIL rst_mid_coll_before got %b want 1", dif.collision); end
      end
      if (c == 10) reset = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({dif.busy, dif.done, dif.collision} !== 3'b000) begin errors++;
      $display("FAIL rst_mid_state got %b want 000", {dif.busy, dif.done, dif.collision}); end
    checks++;
    if ({fb[10][3], fb[11][3], fb[12][3], fb[14][3]} !== 4'b0001) begin errors++;
      $display("FAIL rst_mid_writes got %b want 0001", {fb[10][3], fb[11][3], fb[12][3], fb[14][3]}); end
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (dif.done || dif.busy) fails++;
    end
    checks++;
    if (fails !== 0) begin errors++;
      $display("FAIL rst_mid_quiet got %0d active cycles want 0", fails); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 16; k++) begin
      load_fb(2);
      run_draw($sformatf("rand%0d", k), 8'($urandom), 8'($urandom), 4'($urandom), 16'($urandom), -1);
    end
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom);
    dif.start = 1'b0; dif.vx = '0; dif.vy = '0; dif.n = '0; dif.reg_i = '0;
    reset = 1'b1;
    test_reset();
    test_basic();
    test_xor();
    test_zero();
    test_wrap();
    test_addr_wrap();
    test_start_during_busy();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/chip8_sprite_draw.md
# chip8_sprite_draw

Sequencer for the CHIP-8 DXYN draw instruction. It reads N sprite bytes from main memory starting at I and XORs each bit into the 64x32 framebuffer, one pixel read/write pair per set sprite bit. It reports VF collision when any lit pixel is cleared. It sits between the CPU/top-level execute stage (start/done handshake) and the memory port-1 and framebuffer ports, which the top level muxes to this block while `busy` is high.

## Interface
Parameters:
- FB_X_BITS, 6, framebuffer column address width (64 columns)
- FB_Y_BITS, 5, framebuffer row address width (32 rows)

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high
- start  in  1  request draw; sampled only in IDLE
- vx  in  8  X coordinate (Vx value)
- vy  in  8  Y coordinate (Vy value)
- n  in  4  sprite height in rows
- reg_i  in  16  sprite base address (I)
- busy  out  1  high from the cycle after accepted start through the DONE cycle
- done  out  1  one-cycle pulse at completion
- collision  out  1  VF result; valid with done, held until next accepted start
- mem_addr  out  12  memory read address
- mem_readdata  in  8  memory data, 1-cycle read latency
- fb_rd_x / fb_rd_y  out  FB_X_BITS / FB_Y_BITS  framebuffer read address
- fb_rd_bit  in  1  pixel value, 1-cycle read latency
- fb_wr_x / fb_wr_y  out  FB_X_BITS / FB_Y_BITS  framebuffer write address
- fb_wr_bit  out  1  pixel write value
- fb_we  out  1  pixel write enable

## Operation
- States: IDLE, FETCH, LATCH, PIX_RD, PIX_WR, DONE.
- IDLE + start: latch x0=vx mod 64, y0=vy mod 32, n, base=reg_i[11:0]. Clear collision. Go to FETCH, or to DONE if n==0.
- FETCH: mem_addr = (base + row) mod 4096. Go to LATCH.
- LATCH: capture mem_readdata into the row shift register, col=0. Go to PIX_RD.
- PIX_RD: fb_rd_x = (x0+col) mod 64, fb_rd_y = (y0+row) mod 32. Go to PIX_WR.
- PIX_WR: if sprite bit [7-col] is 1:
  - fb_we=1, fb_wr_bit = ~fb_rd_bit at the same address.
  - collision |= fb_rd_bit.
  - If the sprite bit is 0: no write.
  - Next state: col<7 → PIX_RD with col+1; col==7 and row<n-1 → FETCH with row+1; else → DONE.
- DONE: done=1 → IDLE.
- Coordinates wrap modulo 64/32; no clipping. Pixels within one sprite never alias, so there is no read-after-write hazard.
- start while busy: ignored.
- Reset values: state IDLE, busy 0, done 0, collision 0, fb_we 0, all address outputs 0, fb_wr_bit 0.
- Reset mid-draw: abort immediately. No done. Writes already issued remain.

## Timing
- Fixed latency, data-independent: start accepted in cycle 0 → done in cycle 18n+1. For n=0, done in cycle 1.
- Per row: 2 cycles (FETCH, LATCH) + 16 cycles (8 × PIX_RD/PIX_WR).
- fb_we is asserted only in PIX_WR cycles and is never high for two consecutive cycles.
- Inputs are sampled only on the start cycle. Later changes to vx/vy/n/reg_i have no effect.
- Back-to-back: start in the cycle after done is accepted, because the block is in IDLE.

## Structure
- Add `DRAW_STATE` enum (6 states) and constants `FB_WIDTH=64`, `FB_HEIGHT=32` to the shared enums.svh.
- Single flat module with no sub-module. The counters are row[3:0] and col[2:0], plus an 8-bit sprite register.
- Top-level mux of memory port 1 and framebuffer ports on `busy` is the top level's job, not this block's.

## Test plan
- Basic draw: x=0, y=0, n=1, I=0x050, mem[0x050]=0xF0, empty fb → writes 1 to (0..3,0). collision=0; done at cycle 19.
- XOR/collision: repeat the same draw → (0..3,0) written 0. collision=1; fb unchanged elsewhere.
- Wrap:
  - Stimulus: vx=0x7E, vy=31, n=2, mem[I]=0xC3, mem[I+1]=0x81.
  - Row 0: pixels x=62,63,4,5 at y=31.
  - Row 1: pixels x=62,5 at y=0.
  - done at cycle 37.
- Address wrap and zero height:
  - I=0xFFF, n=2 → mem_addr sequence 0xFFF, 0x000.
  - n=0 → done at cycle 1, no fb_we, collision=0.
- Handshake: start pulsed during busy → ignored, single done. Reset asserted at cycle 10 → state IDLE, no done, busy=0, collision=0 next cycle.
